// File: rtl/counter_readback_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : intel8254_pkg
//  Description : Read/write format codes and status byte layout shared by
//                the 8254 counter datapaths and the control-word decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package intel8254_pkg;

   localparam logic [1:0] RW_LATCH = 2'b00;
   localparam logic [1:0] RW_LSB   = 2'b01;
   localparam logic [1:0] RW_MSB   = 2'b10;
   localparam logic [1:0] RW_LM    = 2'b11;

   localparam int STAT_OUT_BIT   = 7;
   localparam int STAT_NULL_BIT  = 6;
   localparam int STAT_RW_MSB    = 5;
   localparam int STAT_RW_LSB    = 4;
   localparam int STAT_MODE_MSB  = 3;
   localparam int STAT_MODE_LSB  = 1;
   localparam int STAT_BCD_BIT   = 0;

   typedef logic [1:0] rw_fmt_t;

   // The latch-command encoding never reaches a counter as a format; treat it as LSB-then-MSB.
   function automatic rw_fmt_t normalizeRw(input rw_fmt_t rw);
      return (rw == RW_LATCH) ? RW_LM : rw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter_readback_if.sv
`default_nettype none
// ============================================================================
//  Interface   : counter_readback_if
//  Description : Counter-core / bus-side signals of one counter's read path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_readback_if;
   logic [15:0] count_value;
   logic [7:0]  status_value;
   logic [1:0]  rw_mode;
   logic        cw_wr;
   logic        latch_cmd;
   logic        status_cmd;
   logic        rd_en;
   logic [7:0]  data_out;
   logic        data_valid;

   modport master (
      output count_value, status_value, rw_mode,
      output cw_wr, latch_cmd, status_cmd, rd_en,
      input  data_out, data_valid
   );

   modport slave (
      input  count_value, status_value, rw_mode,
      input  cw_wr, latch_cmd, status_cmd, rd_en,
      output data_out, data_valid
   );
endinterface
`default_nettype wire

// File: rtl/counter_readback.sv
`default_nettype none
// ============================================================================
//  Module      : counter_readback
//  Description : 8254 counter read side: count/status latching and LSB/MSB
//                byte sequencing onto the CPU data bus, one byte per read.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_readback
   import intel8254_pkg::*;
#(
   parameter logic [7:0] RESET_BYTE = 8'h00
) (
   input  wire logic         clk,
   input  wire logic         rst,
   counter_readback_if.slave bus
);

   logic        r_countLatched;
   logic [15:0] r_latchReg;
   logic        r_statusLatched;
   logic [7:0]  r_statusReg;
   logic        r_bytePtr;
   logic [7:0]  r_dataOut;
   logic        r_dataValid;

   logic        w_countLatchedNext;
   logic [15:0] w_latchRegNext;
   logic        w_statusLatchedNext;
   logic [7:0]  w_statusRegNext;
   logic        w_bytePtrNext;
   logic [7:0]  w_dataOutNext;
   logic        w_dataValidNext;
   logic [15:0] w_source;
   rw_fmt_t     w_format;

   always_comb begin
      w_source            = r_countLatched ? r_latchReg : bus.count_value;
      w_format            = normalizeRw(bus.rw_mode);
      w_countLatchedNext  = r_countLatched;
      w_latchRegNext      = r_latchReg;
      w_statusLatchedNext = r_statusLatched;
      w_statusRegNext     = r_statusReg;
      w_bytePtrNext       = r_bytePtr;
      w_dataOutNext       = r_dataOut;
      w_dataValidNext     = 1'b0;

      if (bus.cw_wr) begin
         w_countLatchedNext  = 1'b0;
         w_statusLatchedNext = 1'b0;
         w_bytePtrNext       = 1'b0;
      end else begin
         if (bus.rd_en) begin
            w_dataValidNext = 1'b1;
            if (r_statusLatched) begin
               w_dataOutNext       = r_statusReg;
               w_statusLatchedNext = 1'b0;
            end else begin
               case (w_format)
                  RW_LSB: begin
                     w_dataOutNext      = w_source[7:0];
                     w_countLatchedNext = 1'b0;
                  end
                  RW_MSB: begin
                     w_dataOutNext      = w_source[15:8];
                     w_countLatchedNext = 1'b0;
                  end
                  default: begin
                     if (!r_bytePtr) begin
                        w_dataOutNext = w_source[7:0];
                        w_bytePtrNext = 1'b1;
                     end else begin
                        w_dataOutNext      = w_source[15:8];
                        w_bytePtrNext      = 1'b0;
                        w_countLatchedNext = 1'b0;
                     end
                  end
               endcase
            end
         end

         // Commands see the post-read flags, so a read that frees a latch lets a new one in.
         if (bus.latch_cmd && !w_countLatchedNext) begin
            w_latchRegNext     = bus.count_value;
            w_countLatchedNext = 1'b1;
         end
         if (bus.status_cmd && !w_statusLatchedNext) begin
            w_statusRegNext     = bus.status_value;
            w_statusLatchedNext = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_countLatched  <= 1'b0;
         r_latchReg      <= 16'h0000;
         r_statusLatched <= 1'b0;
         r_statusReg     <= 8'h00;
         r_bytePtr       <= 1'b0;
         r_dataOut       <= RESET_BYTE;
         r_dataValid     <= 1'b0;
      end else begin
         r_countLatched  <= w_countLatchedNext;
         r_latchReg      <= w_latchRegNext;
         r_statusLatched <= w_statusLatchedNext;
         r_statusReg     <= w_statusRegNext;
         r_bytePtr       <= w_bytePtrNext;
         r_dataOut       <= w_dataOutNext;
         r_dataValid     <= w_dataValidNext;
      end
   end

   assign bus.data_out   = r_dataOut;
   assign bus.data_valid = r_dataValid;

endmodule
`default_nettype wire

// File: tb/tb_counter_readback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_readback
//  Description : Self-checking bench for counter_readback: directed scenarios
//                plus randomized traffic against a pending-byte queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_readback;

   localparam logic [7:0] C_RESET_BYTE = 8'hA5;

   logic clk;
   logic rst;
   counter_readback_if bus ();

   counter_readback #(.RESET_BYTE(C_RESET_BYTE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCompared   = 0;
   int nMismatched = 0;

   // Model: bytes still owed from a latch, in the order the CPU will get them.
   logic [7:0] countQ[$];
   logic [7:0] statQ[$];
   int         mPtr;
   logic [7:0] expData;
   logic       expValid;

   task automatic step(input logic [15:0] cv, input logic [7:0] sv, input logic [1:0] rw,
                       input logic cw, input logic lc, input logic sc, input logic rd,
                       input logic rs);
      int fmt;
      @(negedge clk);
      bus.count_value  = cv;
      bus.status_value = sv;
      bus.rw_mode      = rw;
      bus.cw_wr        = cw;
      bus.latch_cmd    = lc;
      bus.status_cmd   = sc;
      bus.rd_en        = rd;
      rst              = rs;
      fmt = (rw == 2'b00) ? 3 : int'(rw);
      if (rs) begin
         countQ.delete(); statQ.delete(); mPtr = 0;
         expValid = 1'b0; expData = C_RESET_BYTE;
      end else if (cw) begin
         countQ.delete(); statQ.delete(); mPtr = 0;
         expValid = 1'b0;
      end else begin
         expValid = rd;
         if (rd) begin
            if (statQ.size() > 0) begin
               expData = statQ.pop_front();
            end else begin
               if (countQ.size() > 0) expData = countQ.pop_front();
               else if (fmt == 1)     expData = cv[7:0];
               else if (fmt == 2)     expData = cv[15:8];
               else                   expData = (mPtr == 1) ? cv[15:8] : cv[7:0];
               if (fmt == 3) mPtr = 1 - mPtr;
            end
         end
         if (lc && countQ.size() == 0) begin
            if (fmt == 1)      countQ.push_back(cv[7:0]);
            else if (fmt == 2) countQ.push_back(cv[15:8]);
            else begin
               if (mPtr == 0) countQ.push_back(cv[7:0]);
               countQ.push_back(cv[15:8]);
            end
         end
         if (sc && statQ.size() == 0) statQ.push_back(sv);
      end
      @(posedge clk);
      #1;
      bus.cw_wr = 1'b0; bus.latch_cmd = 1'b0; bus.status_cmd = 1'b0; bus.rd_en = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      step(16'h0000, 8'h00, 2'b11, 0, 0, 0, 1, 1);
      nCompared++;
      if (bus.data_out !== C_RESET_BYTE) begin
         nMismatched++; $display("FAIL reset data_out: got %h want %h", bus.data_out, C_RESET_BYTE);
      end
      nCompared++;
      if (bus.data_valid !== 1'b0) begin
         nMismatched++; $display("FAIL reset data_valid: got %b want 0", bus.data_valid);
      end
   endtask

   task automatic test_live_lsb;
      step(16'h1234, 8'h00, 2'b01, 1, 0, 0, 0, 0);
      step(16'h1234, 8'h00, 2'b01, 0, 0, 0, 1, 0);
      nCompared++;
      if (bus.data_out !== 8'h34 || bus.data_valid !== 1'b1) begin
         nMismatched++; $display("FAIL live_lsb: got %h/%b want 34/1", bus.data_out, bus.data_valid);
      end
      step(16'h9999, 8'h00, 2'b01, 0, 0, 0, 0, 0);
      nCompared++;
      if (bus.data_out !== 8'h34 || bus.data_valid !== 1'b0) begin
         nMismatched++; $display("FAIL live_lsb_hold: got %h/%b want 34/0", bus.data_out, bus.data_valid);
      end
   endtask

   task automatic test_latched_lm;
      logic [7:0] want[3];
      want[0] = 8'hCD; want[1] = 8'hAB; want[2] = 8'h01;
      step(16'hABCD, 8'h00, 2'b11, 1, 0, 0, 0, 0);
      step(16'hABCD, 8'h00, 2'b11, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(16'h0001, 8'h00, 2'b11, 0, 0, 0, 1, 0);
         nCompared++;
         if (bus.data_out !== want[i] || bus.data_valid !== 1'b1) begin
            nMismatched++;
            $display("FAIL latched_lm read%0d: got %h/%b want %h/1", i, bus.data_out, bus.data_valid, want[i]);
         end
      end
   endtask

   task automatic test_repeat_latch;
      step(16'h1111, 8'h00, 2'b11, 1, 0, 0, 0, 0);
      step(16'h1111, 8'h00, 2'b11, 0, 1, 0, 0, 0);
      step(16'h2222, 8'h00, 2'b11, 0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(16'h3333, 8'h00, 2'b11, 0, 0, 0, 1, 0);
         nCompared++;
         if (bus.data_out !== 8'h11) begin
            nMismatched++; $display("FAIL repeat_latch read%0d: got %h want 11", i, bus.data_out);
         end
      end
   endtask

   task automatic test_status_priority;
      step(16'h0000, 8'h00, 2'b10, 1, 0, 0, 0, 0);
      step(16'h5A00, 8'h96, 2'b10, 0, 1, 1, 0, 0);
      step(16'h0000, 8'h00, 2'b10, 0, 0, 0, 1, 0);
      nCompared++;
      if (bus.data_out !== 8'h96) begin
         nMismatched++; $display("FAIL status_first: got %h want 96", bus.data_out);
      end
      step(16'h0000, 8'h00, 2'b10, 0, 0, 0, 1, 0);
      nCompared++;
      if (bus.data_out !== 8'h5A) begin
         nMismatched++; $display("FAIL status_then_count: got %h want 5a", bus.data_out);
      end
   endtask

   task automatic test_mid_clear;
      step(16'h7788, 8'h00, 2'b11, 1, 0, 0, 0, 0);
      step(16'h7788, 8'h00, 2'b11, 0, 1, 0, 0, 0);
      step(16'h0000, 8'h00, 2'b11, 0, 0, 0, 1, 0);
      nCompared++;
      if (bus.data_out !== 8'h88) begin
         nMismatched++; $display("FAIL mid_clear first: got %h want 88", bus.data_out);
      end
      step(16'h0000, 8'h00, 2'b11, 1, 0, 0, 0, 0);
      step(16'h0102, 8'h00, 2'b11, 0, 0, 0, 1, 0);
      nCompared++;
      if (bus.data_out !== 8'h02) begin
         nMismatched++; $display("FAIL mid_clear after_cw: got %h want 02", bus.data_out);
      end
   endtask

   task automatic test_interrupt;
      step(16'h4455, 8'h00, 2'b11, 1, 0, 0, 1, 0);
      nCompared++;
      if (bus.data_valid !== 1'b0) begin
         nMismatched++; $display("FAIL cw_with_rd valid: got %b want 0", bus.data_valid);
      end
      step(16'hBEEF, 8'h00, 2'b11, 0, 1, 0, 0, 0);
      step(16'h0000, 8'h00, 2'b11, 0, 0, 0, 1, 0);
      nCompared++;
      if (bus.data_out !== 8'hEF) begin
         nMismatched++; $display("FAIL rst_mid first: got %h want ef", bus.data_out);
      end
      step(16'h0000, 8'h00, 2'b11, 0, 0, 0, 1, 1);
      nCompared++;
      if (bus.data_valid !== 1'b0) begin
         nMismatched++; $display("FAIL rst_with_rd valid: got %b want 0", bus.data_valid);
      end
      step(16'h6789, 8'h00, 2'b11, 0, 0, 0, 1, 0);
      nCompared++;
      if (bus.data_out !== 8'h89) begin
         nMismatched++; $display("FAIL rst_mid live_lsb: got %h want 89", bus.data_out);
      end
   endtask

   task automatic test_back_to_back_random;
      logic [1:0] rw;
      logic       cw, rs;
      rw = 2'b11;
      step(16'h0000, 8'h00, rw, 1, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         cw = ($urandom_range(0, 15) == 0);
         rs = ($urandom_range(0, 59) == 0);
         if (cw) rw = 2'($urandom_range(0, 3));
         step(16'($urandom), 8'($urandom), rw, cw,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 1) == 0), rs);
         nCompared++;
         if (bus.data_valid !== expValid || bus.data_out !== expData) begin
            nMismatched++;
            $display("FAIL random cycle %0d: got %h/%b want %h/%b", i, bus.data_out, bus.data_valid,
                     expData, expValid);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.count_value = 16'h0000; bus.status_value = 8'h00; bus.rw_mode = 2'b11;
      bus.cw_wr = 1'b0; bus.latch_cmd = 1'b0; bus.status_cmd = 1'b0; bus.rd_en = 1'b0;
      mPtr = 0; expData = C_RESET_BYTE; expValid = 1'b0;
      test_reset();
      test_live_lsb();
      test_latched_lm();
      test_repeat_latch();
      test_status_priority();
      test_mid_clear();
      test_interrupt();
      test_back_to_back_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
`default_nettype wire
